utm_core_project_id: RTL and testbench

UTM_CORE_PROJECT_ID -- requirements
Module: utm_core_project_id

---
 rtl/utm_core_project_id.sv | 82 ++++++++
 tb/tb_utm_core_project_id.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/utm_core_project_id.sv
// utm_core_project_id
// Turing-machine controller running a fixed binary-increment program.
// Tape symbols: 0 = blank, 1 = digit '0', 2 = digit '1', 3..7 undefined.
// Each sym_valid strobe executes one step. The symbol to write and the
// head move appear on the outputs one cycle later and hold until the next step.

module utm_core_project_id (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] sym_in,
   input  logic       sym_valid,
   output logic [2:0] new_sym,
   output logic       direction
);

   // Two-state control: CARRY propagates the increment leftwards and
   // RETURN walks the head back right to the blank past the number.
   typedef enum logic {
      CARRY  = 1'b0,
      RETURN = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] newSym_q, newSym_d;
   logic       dir_q, dir_d;

   // Transition table indexed by {state, symbol}. The defaults implement the
   // pass-through rule for undefined symbols: write the symbol back, move right,
   // and keep the current state.
   always_comb begin
      newSym_d = sym_in;
      dir_d    = 1'b1;
      state_d  = state_q;
      case ({state_q, sym_in})
         {CARRY, 3'd2}: begin
            newSym_d = 3'd1;
            dir_d    = 1'b0;
            state_d  = CARRY;
         end
         {CARRY, 3'd1},
         {CARRY, 3'd0}: begin
            newSym_d = 3'd2;
            dir_d    = 1'b1;
            state_d  = RETURN;
         end
         {RETURN, 3'd1},
         {RETURN, 3'd2}: begin
            newSym_d = sym_in;
            dir_d    = 1'b1;
            state_d  = RETURN;
         end
         {RETURN, 3'd0}: begin
            newSym_d = 3'd0;
            dir_d    = 1'b0;
            state_d  = CARRY;
         end
         default: begin
            newSym_d = sym_in;
            dir_d    = 1'b1;
            state_d  = state_q;
         end
      endcase
   end

   // Register the lookup result on each strobed edge. Reset is asynchronous
   // and takes priority over any step requested on the same edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= CARRY;
         newSym_q <= 3'd0;
         dir_q    <= 1'b0;
      end else if (sym_valid) begin
         state_q  <= state_d;
         newSym_q <= newSym_d;
         dir_q    <= dir_d;
      end
   end

   assign new_sym   = newSym_q;
   assign direction = dir_q;

endmodule

// File: tb/tb_utm_core_project_id.sv
// Testbench for utm_core_project_id.
// The reference model tracks the machine as a phase name plus the last write
// and move. It derives each step from the increment rules: a '1' under the
// carry becomes '0' and the carry continues left. A '0' or blank absorbs the
// carry. The return walk skips digits until it reaches a blank.

module tb_utm_core_project_id;

   logic       clock;
   logic       reset;
   logic [2:0] symIn;
   logic       symValid;
   logic [2:0] newSym;
   logic       direction;

   int checkCount = 0;
   int errorCount = 0;

   // Reference model state
   bit         modelReturning;
   logic [2:0] modelSym;
   logic       modelDir;

   utm_core_project_id dut (
      .clock     (clock),
      .reset     (reset),
      .sym_in    (symIn),
      .sym_valid (symValid),
      .new_sym   (newSym),
      .direction (direction)
   );

   // Free-running 10-unit clock
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Compare one observed value against its expected value and record the result
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      modelReturning = 1'b0;
      modelSym       = 3'd0;
      modelDir       = 1'b0;
   endtask

   // One step of the increment program, computed from its meaning
   task automatic modelStep(input logic [2:0] s);
      if (s > 3'd2) begin
         modelSym = s;
         modelDir = 1'b1;
      end else if (!modelReturning) begin
         if (s == 3'd2) begin
            // digit '1' plus carry gives '0', carry moves left
            modelSym = 3'd1;
            modelDir = 1'b0;
         end else begin
            // digit '0' or blank absorbs the carry and becomes '1'
            modelSym       = 3'd2;
            modelDir       = 1'b1;
            modelReturning = 1'b1;
         end
      end else begin
         if (s == 3'd0) begin
            // reached the blank at the right end, start the next increment
            modelSym       = 3'd0;
            modelDir       = 1'b0;
            modelReturning = 1'b0;
         end else begin
            modelSym = s;
            modelDir = 1'b1;
         end
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, ".new_sym"}, int'(newSym), int'(modelSym));
      checkOutput({tag, ".direction"}, int'(direction), int'(modelDir));
   endtask

   // Drive one cycle from a negedge, then check at the following negedge
   task automatic applyStimulus(input logic [2:0] s, input logic v, input string tag);
      symIn    = s;
      symValid = v;
      @(posedge clock);
      if (v && reset) modelStep(s);
      @(negedge clock);
      symValid = 1'b0;
      checkModel(tag);
   endtask

   task automatic idleCycles(input int n, input string tag);
      for (int i = 0; i < n; i++) applyStimulus(3'($urandom_range(0, 7)), 1'b0, tag);
   endtask

   initial begin
      symIn    = 3'd0;
      symValid = 1'b0;
      reset    = 1'b0;
      modelReset();

      // Reset held low for five cycles, outputs must stay cleared
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         symValid = 1'b1;
         symIn    = 3'($urandom_range(0, 7));
         checkOutput("rst.new_sym", int'(newSym), 0);
         checkOutput("rst.direction", int'(direction), 0);
      end
      symValid = 1'b0;
      reset    = 1'b1;
      idleCycles(3, "postrst_idle");

      // From CARRY: digit '0' absorbs the carry, then RETURN passes digit '0'
      applyStimulus(3'd1, 1'b1, "carry_sym1");
      checkOutput("carry_sym1.lit", int'(newSym), 2);
      applyStimulus(3'd1, 1'b1, "return_sym1");
      checkOutput("return_sym1.lit", int'(newSym), 1);

      // RETURN passes digit '1' twice, with outputs held across idle gaps
      applyStimulus(3'd2, 1'b1, "return_sym2a");
      idleCycles(10, "hold_a");
      applyStimulus(3'd2, 1'b1, "return_sym2b");
      checkOutput("return_sym2b.lit", int'(newSym), 2);
      idleCycles(10, "hold_b");

      // Blank ends RETURN, a digit '1' keeps CARRY, and a blank absorbs the carry
      applyStimulus(3'd0, 1'b1, "return_blank");
      checkOutput("return_blank.dir", int'(direction), 0);
      applyStimulus(3'd2, 1'b1, "carry_sym2");
      checkOutput("carry_sym2.lit", int'(newSym), 1);
      applyStimulus(3'd0, 1'b1, "carry_blank");
      checkOutput("carry_blank.lit", int'(newSym), 2);

      // Undefined symbol in RETURN, then in CARRY, each followed by a probe step
      applyStimulus(3'd5, 1'b1, "undef_return");
      applyStimulus(3'd1, 1'b1, "probe_return");
      applyStimulus(3'd0, 1'b1, "to_carry");
      applyStimulus(3'd5, 1'b1, "undef_carry");
      checkOutput("undef_carry.lit", int'(newSym), 5);
      applyStimulus(3'd1, 1'b1, "probe_carry");

      // Asynchronous reset in the middle of a cycle while in RETURN
      #2;
      reset = 1'b0;
      modelReset();
      #1;
      checkOutput("async_rst.new_sym", int'(newSym), 0);
      checkOutput("async_rst.direction", int'(direction), 0);
      applyStimulus(3'd2, 1'b1, "step_during_rst");
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(3'd1, 1'b1, "after_rst");
      checkOutput("after_rst.lit", int'(newSym), 2);

      // Randomized steps, idles and occasional resets against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b0;
            modelReset();
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "rand_rst");
            reset = 1'b1;
         end else begin
            applyStimulus(3'($urandom_range(0, 2) == 0 ? $urandom_range(3, 7) : $urandom_range(0, 2)),
                          1'($urandom_range(0, 3) != 0), "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
